obf_key_loader: RTL and testbench

Serial key-programming stage that sits directly upstream of an obfuscated gate netlist and drives its `D_*` key inputs. It shifts in `2*N_SITES` key bits plus one even-parity bit, checks them, and commits them to a registered key bus. Each 2-bit site code selects pass, invert, constant-1 or constant-0 at one obfuscated net. Until a valid key is committed, every site is forced to constant-0, so the protected function stays masked.

---
 rtl/obf_key_pkg.sv | 30 +++
 rtl/obf_key_shreg.sv | 39 +++
 rtl/obf_key_loader.sv | 117 +++++++++++
 tb/tb_obf_key_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/obf_key_pkg.sv
// Shared types and constants for the obfuscation key loader.
// Site codes are {D_2k, D_2k+1}; the mask value drives every site to constant 0.
package obf_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_LOCKED,
    ST_ERROR
  } state_t;

  localparam logic [1:0] KEY_PASS = 2'b00;
  localparam logic [1:0] KEY_INV  = 2'b01;
  localparam logic [1:0] KEY_ONE  = 2'b10;
  localparam logic [1:0] KEY_ZERO = 2'b11;

  // Upper bound on key width supported by key_mask(); callers slice the low bits.
  localparam int MAX_KEY_W = 64;

  function automatic logic [MAX_KEY_W-1:0] key_mask(input int n);
    logic [MAX_KEY_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KEY_W / 2; i++) begin
      if (i < n) m[2*i +: 2] = KEY_ZERO;
    end
    return m;
  endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// Shadow register, saturating bit counter and running parity for serial key loads.
// Bit n lands in shadow[n]; the bit taken at count == KEY_W is the parity bit.
module obf_key_shreg #(
  parameter int KEY_W = 10,
  parameter int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic [CNT_W-1:0] count,
  output logic             parity
);

  localparam logic [CNT_W-1:0] PARITY_POS = CNT_W'(KEY_W);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      shadow <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (shift_en) begin
      parity <= parity ^ bit_in;
      for (int i = 0; i < KEY_W; i++) begin
        if (count == CNT_W'(i)) shadow[i] <= bit_in;
      end
      // Saturate at the parity position so the counter never wraps.
      if (count != PARITY_POS) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader: shifts in KEY_W key bits plus even parity, then commits the key
// to a registered bus. The bus holds the all-constant-0 mask until a load is LOCKED.
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int N_SITES = 5,
  parameter int KEY_W   = 2 * N_SITES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_start_i,
  input  logic             key_bit_i,
  input  logic             key_bit_valid_i,
  output logic             key_bit_ready_o,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid_o,
  output logic             load_err_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [MAX_KEY_W-1:0] MASK_FULL = key_mask(N_SITES);
  localparam logic [KEY_W-1:0]     MASK      = MASK_FULL[KEY_W-1:0];
  localparam logic [CNT_W-1:0]     PARITY_POS = CNT_W'(KEY_W);

  state_t           state, state_nxt;
  logic             shreg_clr, shift_en;
  logic             commit, fail;
  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] count;
  logic             parity;

  obf_key_shreg #(
    .KEY_W (KEY_W),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clr      (shreg_clr),
    .shift_en (shift_en),
    .bit_in   (key_bit_i),
    .shadow   (shadow),
    .count    (count),
    .parity   (parity)
  );

  // A bit offered while a restart or clear is pending would be discarded, so the
  // handshake is withheld in those cycles rather than silently dropping the bit.
  assign key_bit_ready_o = (state == ST_SHIFT) && !load_start_i && !clear_i;
  assign busy_o          = (state == ST_SHIFT) || (state == ST_CHECK);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    shreg_clr = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    fail      = 1'b0;
    if (clear_i) begin
      state_nxt = ST_IDLE;
      shreg_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (load_start_i) begin
            shreg_clr = 1'b1;
            state_nxt = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (load_start_i) begin
            shreg_clr = 1'b1;
          end else if (key_bit_valid_i) begin
            shift_en = 1'b1;
            if (count == PARITY_POS) state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (parity) begin
            fail      = 1'b1;
            state_nxt = ST_ERROR;
          end else begin
            commit    = 1'b1;
            state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: state_nxt = ST_LOCKED;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      key_o       <= MASK;
      key_valid_o <= 1'b0;
      load_err_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear_i) begin
        key_o       <= MASK;
        key_valid_o <= 1'b0;
        load_err_o  <= 1'b0;
      end else if (commit) begin
        key_o       <= shadow;
        key_valid_o <= 1'b1;
      end else if (fail) begin
        load_err_o  <= 1'b1;
      end else if (state == ST_ERROR && load_start_i) begin
        load_err_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_obf_key_loader.sv
// Self-checking bench for obf_key_loader (N_SITES=5, KEY_W=10): expected load results
// are queued when a full load is driven and compared when the DUT leaves CHECK.
module tb_obf_key_loader;

  localparam int KEY_W = 10;
  localparam logic [KEY_W-1:0] MASK = 10'h3FF;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear_i;
  logic             load_start_i;
  logic             key_bit_i;
  logic             key_bit_valid_i;
  logic             key_bit_ready_o;
  logic [KEY_W-1:0] key_o;
  logic             key_valid_o;
  logic             load_err_o;
  logic             busy_o;

  obf_key_loader #(.N_SITES(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (clear_i),
    .load_start_i    (load_start_i),
    .key_bit_i       (key_bit_i),
    .key_bit_valid_i (key_bit_valid_i),
    .key_bit_ready_o (key_bit_ready_o),
    .key_o           (key_o),
    .key_valid_o     (key_valid_o),
    .load_err_o      (load_err_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             valid;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key plus its even-parity bit; bad=1 flips the parity.
  function automatic logic [KEY_W:0] mk_word(input logic [KEY_W-1:0] key, input logic bad);
    return {(^key) ^ bad, key};
  endfunction

  task automatic start_load();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    check("start_busy", busy_o, 1);
    check("start_err_clear", load_err_o, 0);
  endtask

  task automatic send_bits(input logic [KEY_W:0] word, input int nbits, input int max_gap);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 1);
        key_bit_valid_i = 1'b0;
        repeat (g) tick();
      end
      key_bit_valid_i = 1'b1;
      key_bit_i       = word[i];
      #1;
      check("ready_in_shift", key_bit_ready_o, 1);
      tick();
    end
    key_bit_valid_i = 1'b0;
    if (nbits == KEY_W + 1) begin
      e.err   = ^word;
      e.valid = ~e.err;
      e.key   = e.err ? MASK : word[KEY_W-1:0];
      sb_q.push_back(e);
    end
  endtask

  // Called right after the parity bit's accepting edge: one CHECK cycle, then result.
  task automatic collect();
    exp_t e;
    check("check_busy", busy_o, 1);
    check("check_not_valid", key_valid_o, 0);
    tick();
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("key_o", key_o, e.key);
      check("key_valid", key_valid_o, e.valid);
      check("load_err", load_err_o, e.err);
      check("post_busy", busy_o, 0);
      check("post_ready", key_bit_ready_o, 0);
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  logic [KEY_W:0] good_w, alt_w, rnd_w;

  initial begin
    rst = 1'b1; clear_i = 1'b0; load_start_i = 1'b0;
    key_bit_i = 1'b0; key_bit_valid_i = 1'b0;
    good_w = mk_word(10'b1000110100, 1'b0);
    alt_w  = mk_word(10'b0101100110, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_key", key_o, MASK);
    check("rst_valid", key_valid_o, 0);
    check("rst_err", load_err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", key_bit_ready_o, 0);
    rst = 1'b0;
    tick();
    check("idle_ready", key_bit_ready_o, 0);

    // Good load.
    start_load();
    send_bits(good_w, KEY_W + 1, 0);
    collect();

    // load_start and bits ignored in LOCKED.
    load_start_i = 1'b1; key_bit_valid_i = 1'b1; key_bit_i = 1'b1;
    #1;
    check("locked_ready", key_bit_ready_o, 0);
    tick();
    load_start_i = 1'b0; key_bit_valid_i = 1'b0;
    check("locked_keep_valid", key_valid_o, 1);
    check("locked_keep_key", key_o, 10'b1000110100);
    check("locked_busy", busy_o, 0);

    // Clear wins over load_start in LOCKED.
    clear_i = 1'b1; load_start_i = 1'b1;
    tick();
    clear_i = 1'b0; load_start_i = 1'b0;
    check("clr_key", key_o, MASK);
    check("clr_valid", key_valid_o, 0);
    check("clr_busy", busy_o, 0);
    check("clr_ready", key_bit_ready_o, 0);
    tick();
    check("clr_no_load", busy_o, 0);

    // Parity error, then retry from ERROR.
    start_load();
    send_bits(mk_word(10'b1000110100, 1'b1), KEY_W + 1, 0);
    collect();
    tick();
    check("err_hold", load_err_o, 1);
    check("err_key_masked", key_o, MASK);
    start_load();
    send_bits(good_w, KEY_W + 1, 0);
    collect();
    do_clear();

    // Stall tolerance.
    start_load();
    send_bits(good_w, KEY_W + 1, 5);
    collect();
    do_clear();
    for (int k = 0; k < 3; k++) begin
      rnd_w = mk_word(KEY_W'($urandom), 1'($urandom_range(1, 0)));
      start_load();
      send_bits(rnd_w, KEY_W + 1, 3);
      collect();
      do_clear();
    end

    // Restart mid-load with a valid bit offered in the restart cycle.
    start_load();
    send_bits(11'h7FF, 6, 0);
    load_start_i = 1'b1; key_bit_valid_i = 1'b1; key_bit_i = 1'b1;
    #1;
    check("restart_ready_low", key_bit_ready_o, 0);
    tick();
    load_start_i = 1'b0; key_bit_valid_i = 1'b0;
    check("restart_busy", busy_o, 1);
    send_bits(alt_w, KEY_W + 1, 0);
    collect();

    // Async reset from LOCKED, between edges.
    #2 rst = 1'b1;
    #1;
    check("arst_locked_key", key_o, MASK);
    check("arst_locked_valid", key_valid_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // Async reset mid-load after 4 bits.
    start_load();
    send_bits(good_w, 4, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_ready", key_bit_ready_o, 0);
    check("arst_key", key_o, MASK);
    check("arst_valid", key_valid_o, 0);
    check("arst_err", load_err_o, 0);
    tick();
    rst = 1'b0;
    key_bit_valid_i = 1'b1; key_bit_i = 1'b0;
    repeat (3) tick();
    key_bit_valid_i = 1'b0;
    check("post_rst_idle_busy", busy_o, 0);
    check("post_rst_idle_ready", key_bit_ready_o, 0);
    check("post_rst_valid", key_valid_o, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
